reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- RV32I integer register file for the multi-cycle, unpipelined core.
- Source end of the operand path: drives read_data_1/read_data_2 into the A/B operand latches.
- Sink end of the write-back path: accepts rd writes from the write-back state.
- 32 x 32-bit registers; x0 hardwired to zero; reset clears all registers; includes a debug read port and a retired-write counter for verification.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (addresses are log2(NREGS) = 5 bits).
- BYPASS, 1, 1 = a read of the register being written in the same cycle returns write_data; 0 = it returns the stored old value.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- rs1_addr  input  5  source register 1 index.
- rs2_addr  input  5  source register 2 index.
- rd_addr  input  5  destination register index.
- write_data  input  XLEN  write-back value.
- reg_write  input  1  write enable, sampled on the rising edge of clk.
- read_data_1  output  XLEN  combinational contents of rs1.
- read_data_2  output  XLEN  combinational contents of rs2.
- dbg_addr  input  5  debug/test read index.
- dbg_data  output  XLEN  combinational contents of dbg_addr; never bypassed.
- wr_count  output  CNT_W  number of committed writes to rd != 0.

Behaviour:
- Reset: clk and rst are as already decided — reset rst, asynchronous, active-low; clock clk.
  - rst low immediately clears all registers x1..x31 and wr_count to 0.
  - All read outputs therefore read 0 while rst is low, and reg_write is ignored.
- Reset mid-operation: a write whose rising edge coincides with rst low is discarded, and wr_count does not increment.
- Write:
  - On the rising edge of clk with rst high, reg_write=1 and rd_addr!=0: regs[rd_addr] <= write_data and wr_count <= wr_count+1.
  - Write latency is 1 cycle; the new value is visible on the read ports after the edge.
- x0:
  - Writes with rd_addr=0 are dropped and do not count.
  - Any read of index 0 returns 0 regardless of BYPASS.
- Read:
  - Purely combinational, 0-cycle latency; no clock or enable involved.
  - The two read ports and the debug port are independent.
  - rs1_addr == rs2_addr is legal and both ports return identical data.
- Bypass (BYPASS=1): if reg_write=1, rd_addr!=0 and rs*_addr==rd_addr in the same cycle, read_data_* = write_data.
  - In the multi-cycle core, decode and write-back never overlap, so BYPASS only affects same-cycle observability.
  - Both settings must be functionally correct for the core.
- Counter: wr_count wraps modulo 2^CNT_W with no saturation and no flag.
- No X propagation: every register has a defined reset value; addresses are always in range because NREGS = 2^5.

Decomposition:
- Shared package (rv32_pkg):
  - XLEN;
  - REG_ADDR_W = 5;
  - ZERO_REG = 0;
  - named ABI register indices used by benches (RA = 1, SP = 2).
- No sub-module: storage array plus read muxes in one module.
- The read mux with zero/bypass selection is written once and replicated per port as a function, not as a separate instance.

Test Plan:
- Reset: hold rst=0 with random addresses and reg_write=1 -> read_data_1, read_data_2, dbg_data and wr_count all 0; release, read x1..x31 -> all 0.
- Basic write/read:
  - write x5=0xDEADBEEF, then x6=0x12345678, rs1=5, rs2=6 -> read_data_1=0xDEADBEEF, read_data_2=0x12345678, wr_count=2.
  - Then rs1=rs2=5 -> both ports 0xDEADBEEF.
- x0: reg_write=1, rd_addr=0, write_data=0xFFFFFFFF -> rs1=0 reads 0, dbg_addr=0 reads 0, wr_count unchanged.
- Bypass:
  - With x7=0x1111 stored, drive reg_write=1, rd=7, write_data=0x2222, rs1=7 in the same cycle -> read_data_1=0x2222 when BYPASS=1, 0x1111 when BYPASS=0; dbg_data=0x1111 in both cases.
  - After the edge, all ports read 0x2222.
- Async reset mid-run: write x10=0xA5A5A5A5, assert rst low between clock edges -> read_data_1 (rs1=10) drops to 0 without waiting for a clock edge, wr_count=0; a write edge during reset is discarded.
- Counter wrap: with CNT_W=4, perform 17 writes to x1..x31 -> wr_count=1.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: data width, register index width and the
// ABI register names the benches use.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
  localparam reg_addr_t RA       = 5'd1;
  localparam reg_addr_t SP       = 5'd2;

endpackage

// File: rtl/reg_file.sv
// RV32I integer register file: two operand read ports, one write-back port,
// a never-bypassed debug read port and a count of committed writes.
module reg_file
  import rv32_pkg::*;
#(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       write_data,
  input  logic                  reg_write,
  output logic [XLEN-1:0]       read_data_1,
  output logic [XLEN-1:0]       read_data_2,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]       dbg_data,
  output logic [CNT_W-1:0]      wr_count
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [CNT_W-1:0] count;
  logic             wr_en;

  // x0 writes never reach storage, so regs[0] stays at its reset value of zero.
  assign wr_en = reg_write && (rd_addr != ZERO_REG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      count <= '0;
    end else if (wr_en) begin
      regs[rd_addr] <= write_data;
      count         <= count + CNT_W'(1);
    end
  end

  // Bypass is gated by rst so a held reset keeps every read port at zero.
  function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] addr,
                                                input logic bypass_en);
    if (addr == ZERO_REG) begin
      return '0;
    end
    if (bypass_en && wr_en && rst && (addr == rd_addr)) begin
      return write_data;
    end
    return regs[addr];
  endfunction

  always_comb begin
    read_data_1 = read_port(rs1_addr, BYPASS != 0);
    read_data_2 = read_port(rs2_addr, BYPASS != 0);
    dbg_data    = read_port(dbg_addr, 1'b0);
  end

  assign wr_count = count;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a bypassing 32-bit-counter instance and a
// non-bypassing 4-bit-counter instance share stimulus against a register model.
module tb_reg_file;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] rd1_a, rd2_a, dbg_a, cnt_a;
  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [32];
  int unsigned mdl_cnt = 0;
  logic [31:0] sb_q [$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  reg_file #(.BYPASS(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .write_data(write_data), .reg_write(reg_write),
    .read_data_1(rd1_a), .read_data_2(rd2_a), .dbg_addr(dbg_addr),
    .dbg_data(dbg_a), .wr_count(cnt_a));

  reg_file #(.BYPASS(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .write_data(write_data), .reg_write(reg_write),
    .read_data_1(rd1_b), .read_data_2(rd2_b), .dbg_addr(dbg_addr),
    .dbg_data(dbg_b), .wr_count(cnt_b));

  // Drives one write cycle and mirrors its architectural effect into the model.
  task automatic drive_write(input logic [4:0] rd, input logic [31:0] d);
    @(negedge clk);
    rd_addr = rd; write_data = d; reg_write = 1'b1;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    if (rst && rd != 5'd0) begin
      mdl[rd] = d;
      mdl_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rs1_addr = 5'($urandom); rs2_addr = 5'($urandom); dbg_addr = 5'($urandom);
      rd_addr = rs1_addr; write_data = $urandom; reg_write = 1'b1;
      sb_q.push_back(32'd0);
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      checks += 5;
      if (rd1_a !== exp) begin errors++; $display("[TB] FAIL reset_rd1: got %h expected %h", rd1_a, exp); end
      if (rd2_a !== exp) begin errors++; $display("[TB] FAIL reset_rd2: got %h expected %h", rd2_a, exp); end
      if (dbg_a !== exp) begin errors++; $display("[TB] FAIL reset_dbg: got %h expected %h", dbg_a, exp); end
      if (cnt_a !== exp) begin errors++; $display("[TB] FAIL reset_cnt_a: got %0d expected %0d", cnt_a, exp); end
      if (cnt_b !== exp[3:0]) begin errors++; $display("[TB] FAIL reset_cnt_b: got %0d expected %0d", cnt_b, exp[3:0]); end
    end
    @(negedge clk);
    reg_write = 1'b0;
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); dbg_addr = 5'(i);
      sb_q.push_back(mdl[i]);
      #1;
      exp = sb_q.pop_front();
      checks += 2;
      if (rd1_a !== exp) begin errors++; $display("[TB] FAIL post_reset_x%0d: got %h expected %h", i, rd1_a, exp); end
      if (dbg_b !== exp) begin errors++; $display("[TB] FAIL post_reset_dbg_x%0d: got %h expected %h", i, dbg_b, exp); end
    end
  endtask

  task automatic test_basic();
    drive_write(5'd5, 32'hDEADBEEF);
    drive_write(5'd6, 32'h12345678);
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    sb_q.push_back(mdl[5]); sb_q.push_back(mdl[6]); sb_q.push_back(mdl_cnt);
    #1;
    exp = sb_q.pop_front(); checks += 2;
    if (rd1_a !== exp) begin errors++; $display("[TB] FAIL basic_rd1_a: got %h expected %h", rd1_a, exp); end
    if (rd1_b !== exp) begin errors++; $display("[TB] FAIL basic_rd1_b: got %h expected %h", rd1_b, exp); end
    exp = sb_q.pop_front(); checks += 2;
    if (rd2_a !== exp) begin errors++; $display("[TB] FAIL basic_rd2_a: got %h expected %h", rd2_a, exp); end
    if (rd2_b !== exp) begin errors++; $display("[TB] FAIL basic_rd2_b: got %h expected %h", rd2_b, exp); end
    exp = sb_q.pop_front(); checks += 2;
    if (cnt_a !== exp) begin errors++; $display("[TB] FAIL basic_cnt_a: got %0d expected %0d", cnt_a, exp); end
    if (cnt_b !== exp[3:0]) begin errors++; $display("[TB] FAIL basic_cnt_b: got %0d expected %0d", cnt_b, exp[3:0]); end
    rs2_addr = 5'd5;
    sb_q.push_back(mdl[5]);
    #1;
    exp = sb_q.pop_front(); checks += 2;
    if (rd1_a !== exp) begin errors++; $display("[TB] FAIL same_addr_rd1: got %h expected %h", rd1_a, exp); end
    if (rd2_a !== exp) begin errors++; $display("[TB] FAIL same_addr_rd2: got %h expected %h", rd2_a, exp); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    rd_addr = ZERO_REG; write_data = 32'hFFFFFFFF; reg_write = 1'b1;
    rs1_addr = ZERO_REG; dbg_addr = ZERO_REG;
    sb_q.push_back(32'd0);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (rd1_a !== exp) begin errors++; $display("[TB] FAIL x0_bypass_rd1: got %h expected %h", rd1_a, exp); end
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    sb_q.push_back(32'd0); sb_q.push_back(mdl_cnt);
    exp = sb_q.pop_front(); checks += 2;
    if (rd1_a !== exp) begin errors++; $display("[TB] FAIL x0_rd1: got %h expected %h", rd1_a, exp); end
    if (dbg_a !== exp) begin errors++; $display("[TB] FAIL x0_dbg: got %h expected %h", dbg_a, exp); end
    exp = sb_q.pop_front(); checks += 2;
    if (cnt_a !== exp) begin errors++; $display("[TB] FAIL x0_cnt_a: got %0d expected %0d", cnt_a, exp); end
    if (cnt_b !== exp[3:0]) begin errors++; $display("[TB] FAIL x0_cnt_b: got %0d expected %0d", cnt_b, exp[3:0]); end
  endtask

  task automatic test_bypass();
    drive_write(5'd7, 32'h1111);
    @(negedge clk);
    rd_addr = 5'd7; write_data = 32'h2222; reg_write = 1'b1;
    rs1_addr = 5'd7; dbg_addr = 5'd7;
    sb_q.push_back(32'h2222); sb_q.push_back(32'h1111);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (rd1_a !== exp) begin errors++; $display("[TB] FAIL bypass_on_rd1: got %h expected %h", rd1_a, exp); end
    exp = sb_q.pop_front(); checks += 3;
    if (rd1_b !== exp) begin errors++; $display("[TB] FAIL bypass_off_rd1: got %h expected %h", rd1_b, exp); end
    if (dbg_a !== exp) begin errors++; $display("[TB] FAIL bypass_on_dbg: got %h expected %h", dbg_a, exp); end
    if (dbg_b !== exp) begin errors++; $display("[TB] FAIL bypass_off_dbg: got %h expected %h", dbg_b, exp); end
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    mdl[7] = 32'h2222; mdl_cnt++;
    sb_q.push_back(mdl[7]);
    #1;
    exp = sb_q.pop_front(); checks += 4;
    if (rd1_a !== exp) begin errors++; $display("[TB] FAIL after_bypass_rd1_a: got %h expected %h", rd1_a, exp); end
    if (rd1_b !== exp) begin errors++; $display("[TB] FAIL after_bypass_rd1_b: got %h expected %h", rd1_b, exp); end
    if (dbg_a !== exp) begin errors++; $display("[TB] FAIL after_bypass_dbg_a: got %h expected %h", dbg_a, exp); end
    if (dbg_b !== exp) begin errors++; $display("[TB] FAIL after_bypass_dbg_b: got %h expected %h", dbg_b, exp); end
  endtask

  task automatic test_random();
    drive_write(RA, $urandom);
    drive_write(SP, $urandom);
    for (int n = 0; n < 30; n++) begin
      drive_write(5'($urandom), $urandom);
      rs1_addr = 5'($urandom); rs2_addr = 5'($urandom); dbg_addr = 5'($urandom);
      sb_q.push_back(mdl[rs1_addr]); sb_q.push_back(mdl[rs2_addr]); sb_q.push_back(mdl[dbg_addr]);
      #1;
      exp = sb_q.pop_front(); checks += 2;
      if (rd1_a !== exp) begin errors++; $display("[TB] FAIL rand_rd1_a x%0d: got %h expected %h", rs1_addr, rd1_a, exp); end
      if (rd1_b !== exp) begin errors++; $display("[TB] FAIL rand_rd1_b x%0d: got %h expected %h", rs1_addr, rd1_b, exp); end
      exp = sb_q.pop_front(); checks += 2;
      if (rd2_a !== exp) begin errors++; $display("[TB] FAIL rand_rd2_a x%0d: got %h expected %h", rs2_addr, rd2_a, exp); end
      if (rd2_b !== exp) begin errors++; $display("[TB] FAIL rand_rd2_b x%0d: got %h expected %h", rs2_addr, rd2_b, exp); end
      exp = sb_q.pop_front(); checks += 2;
      if (dbg_a !== exp) begin errors++; $display("[TB] FAIL rand_dbg_a x%0d: got %h expected %h", dbg_addr, dbg_a, exp); end
      if (dbg_b !== exp) begin errors++; $display("[TB] FAIL rand_dbg_b x%0d: got %h expected %h", dbg_addr, dbg_b, exp); end
    end
    sb_q.push_back(mdl_cnt);
    exp = sb_q.pop_front(); checks += 2;
    if (cnt_a !== exp) begin errors++; $display("[TB] FAIL rand_cnt_a: got %0d expected %0d", cnt_a, exp); end
    if (cnt_b !== exp[3:0]) begin errors++; $display("[TB] FAIL rand_cnt_b: got %0d expected %0d", cnt_b, exp[3:0]); end
  endtask

  task automatic test_async_reset();
    drive_write(5'd10, 32'hA5A5A5A5);
    rs1_addr = 5'd10;
    sb_q.push_back(mdl[10]);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (rd1_a !== exp) begin errors++; $display("[TB] FAIL pre_reset_x10: got %h expected %h", rd1_a, exp); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_cnt = 0;
    sb_q.push_back(mdl[10]); sb_q.push_back(mdl_cnt);
    #1;
    exp = sb_q.pop_front(); checks += 2;
    if (rd1_a !== exp) begin errors++; $display("[TB] FAIL async_rd1_a: got %h expected %h", rd1_a, exp); end
    if (rd1_b !== exp) begin errors++; $display("[TB] FAIL async_rd1_b: got %h expected %h", rd1_b, exp); end
    exp = sb_q.pop_front(); checks += 2;
    if (cnt_a !== exp) begin errors++; $display("[TB] FAIL async_cnt_a: got %0d expected %0d", cnt_a, exp); end
    if (cnt_b !== exp[3:0]) begin errors++; $display("[TB] FAIL async_cnt_b: got %0d expected %0d", cnt_b, exp[3:0]); end
    rd_addr = 5'd3; write_data = 32'h3333; reg_write = 1'b1; rs1_addr = 5'd3;
    @(posedge clk);
    #1;
    @(negedge clk);
    reg_write = 1'b0;
    rst = 1'b1;
    sb_q.push_back(mdl[3]); sb_q.push_back(mdl_cnt);
    #1;
    exp = sb_q.pop_front(); checks++;
    if (rd1_a !== exp) begin errors++; $display("[TB] FAIL reset_write_dropped: got %h expected %h", rd1_a, exp); end
    exp = sb_q.pop_front(); checks++;
    if (cnt_a !== exp) begin errors++; $display("[TB] FAIL reset_write_cnt: got %0d expected %0d", cnt_a, exp); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      drive_write(5'(i % 31 + 1), $urandom);
    end
    sb_q.push_back(mdl_cnt);
    exp = sb_q.pop_front(); checks += 2;
    if (cnt_a !== exp) begin errors++; $display("[TB] FAIL wrap_cnt_a: got %0d expected %0d", cnt_a, exp); end
    if (cnt_b !== exp[3:0]) begin errors++; $display("[TB] FAIL wrap_cnt_b: got %0d expected %0d", cnt_b, exp[3:0]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    rst = 1'b0; reg_write = 1'b0; write_data = '0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0; dbg_addr = '0;
    test_reset();
    test_basic();
    test_x0();
    test_bypass();
    test_random();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
